psr_cc_stack: RTL
=================

// Module: psr_cc_stack
// PURPOSE
//  Processor status unit for the LC-3 datapath: owns the N/Z/P condition codes, privilege bit and 3-bit
//  priority level, i.e. the full 16-bit PSR. Updates CCs from any DATA_W-bit result, evaluates BR nzp masks,
//  and keeps a hardware stack of saved PSRs for nested interrupt entry / RTI. Sits beside the register file.
// PARAMETERS
//  DATA_W       16  width of result bus; sign = result[DATA_W-1]
//  STACK_DEPTH   4  saved-PSR entries (>=1); counter width $clog2(STACK_DEPTH+1)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  result       in   DATA_W  value to classify for CC update
//  cc_write     in   1       load N/Z/P from result
//  br_eval      in   1       evaluate branch with br_nzp
//  br_nzp       in   3       branch mask {n,z,p}
//  br_taken     out  1       registered branch decision
//  int_enter    in   1       push PSR, enter supervisor at int_pri
//  int_pri      in   3       new priority on int_enter
//  rti          in   1       pop PSR
//  psr_write    in   1       load PSR from psr_wdata
//  psr_wdata    in   16      {priv,4'b0,pri[2:0],5'b0,n,z,p}
//  err_clr      in   1       clear stk_err
//  psr_out      out  16      {priv,4'b0,pri,5'b0,n,z,p}
//  n_flag/z_flag/p_flag out 1 each  current CCs
//  stk_full / stk_empty out 1 each  depth==STACK_DEPTH / depth==0
//  stk_err      out  1       sticky overflow/underflow
// BEHAVIOUR
//  - Reset (async, immediate): n=0 z=1 p=0, priv=1 (user), pri=0, depth=0, br_taken=0, stk_err=0.
//  - Invariant: exactly one of n/z/p is set at all times.
//  - CC classify: result[DATA_W-1]=1 -> N; result==0 -> Z; else P. Registered, visible 1 cycle after cc_write.
//  - Same-edge priority: int_enter > rti > psr_write > cc_write; losers are dropped for that cycle.
//  - int_enter: push current (pre-edge) PSR; priv<=0, pri<=int_pri, CCs unchanged. If full: no push, depth
//    holds, stk_err<=1, but priv/pri still update.
//  - rti: pop top entry into PSR, depth-1. If empty: PSR unchanged, stk_err<=1.
//  - psr_write: loads priv, pri, nzp; nzp not one-hot -> forced to 3'b010.
//  - Stack is LIFO, top at index depth-1; nested pushes/pops restore in reverse order.
//  - br_taken <= br_eval & |(br_nzp & {n,z,p}); latency 1; 0 in cycles after br_eval=0.
//  - stk_err cleared only by reset or err_clr; err_clr with new error same edge -> error wins (stays 1).
//  - psr_out, flags, stk_full/stk_empty are direct register decodes (no combinational path from inputs).
// CONFIGURATION
//  CC_FORWARD_EN defined: br_taken uses the flags being written this cycle (classified result if cc_write
//    wins, popped nzp on rti, psr_wdata nzp on psr_write) -> back-to-back ALU+BR needs no stall.
//  CC_FORWARD_EN undefined: br_taken uses pre-edge registered flags; pipeline must insert one bubble.
// TESTING
//  1 reset mid-run, then release -> psr_out=16'h8002, stk_empty=1, br_taken=0, stk_err=0.
//  2 cc_write result=16'h8000 / 16'h0000 / 16'h0001 -> n/z/p each one-hot next cycle; DATA_W=8 with 8'h80 -> N.
//  3 PSR=8002, int_enter pri=4 x2 (pri 6 second), rti x2 -> psr_out 0602,0402 then 8002; stk_empty=1.
//  4 STACK_DEPTH+1 int_enter -> stk_full=1, last push dropped, stk_err=1; rti on empty -> PSR unchanged.
//  5 cc_write result=0 with br_eval, br_nzp=3'b010 same cycle -> br_taken=1 with CC_FORWARD_EN, else 0.
//  6 int_enter+cc_write+rti same edge -> only push happens; psr_write nzp=3'b110 -> z only.

Source files
------------

// File: rtl/psr_cc_stack.sv
// LC-3 processor status unit: N/Z/P condition codes, privilege, priority and a LIFO of saved PSRs.
// Latency: every output is registered and changes one cycle after the causing input. No backpressure:
// strobes are accepted every cycle. Define CC_FORWARD_EN to branch on the flags written in the same cycle.
module psr_cc_stack #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] result,
    input  logic              cc_write,
    input  logic              br_eval,
    input  logic [2:0]        br_nzp,
    output logic              br_taken,
    input  logic              int_enter,
    input  logic [2:0]        int_pri,
    input  logic              rti,
    input  logic              psr_write,
    input  logic [15:0]       psr_wdata,
    input  logic              err_clr,
    output logic [15:0]       psr_out,
    output logic              n_flag,
    output logic              z_flag,
    output logic              p_flag,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    typedef struct packed {
        logic       priv;
        logic [2:0] pri;
        logic [2:0] nzp;
    } psr_t;

    psr_t             psr_q, psr_d;
    psr_t             stk_q [STACK_DEPTH];
    psr_t             stk_d [STACK_DEPTH];
    psr_t             stk_top;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic             br_taken_q, br_taken_d;
    logic             stk_err_q, stk_err_d;
    logic [2:0]       cls_nzp;
    logic [2:0]       wr_nzp;
    logic [2:0]       br_flags;
    logic             is_full, is_empty;

    assign is_full  = (depth_q == CNT_W'(STACK_DEPTH));
    assign is_empty = (depth_q == '0);

    always_comb begin
        cls_nzp = 3'b001;
        if (result[DATA_W-1])
            cls_nzp = 3'b100;
        else if (result == '0)
            cls_nzp = 3'b010;

        // A malformed CC field must never break the one-hot invariant; fall back to Z.
        wr_nzp = psr_wdata[2:0];
        if (!(wr_nzp == 3'b100 || wr_nzp == 3'b010 || wr_nzp == 3'b001))
            wr_nzp = 3'b010;

        stk_top = psr_q;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (depth_q == CNT_W'(i + 1))
                stk_top = stk_q[i];
    end

    always_comb begin
        psr_d     = psr_q;
        depth_d   = depth_q;
        stk_d     = stk_q;
        stk_err_d = stk_err_q & ~err_clr;

        if (int_enter) begin
            if (is_full) begin
                stk_err_d = 1'b1;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++)
                    if (depth_q == CNT_W'(i))
                        stk_d[i] = psr_q;
                depth_d = depth_q + CNT_W'(1);
            end
            psr_d.priv = 1'b0;
            psr_d.pri  = int_pri;
        end else if (rti) begin
            if (is_empty) begin
                stk_err_d = 1'b1;
            end else begin
                psr_d   = stk_top;
                depth_d = depth_q - CNT_W'(1);
            end
        end else if (psr_write) begin
            psr_d.priv = psr_wdata[15];
            psr_d.pri  = psr_wdata[10:8];
            psr_d.nzp  = wr_nzp;
        end else if (cc_write) begin
            psr_d.nzp = cls_nzp;
        end

`ifdef CC_FORWARD_EN
        br_flags = psr_d.nzp;
`else
        br_flags = psr_q.nzp;
`endif
        br_taken_d = br_eval & |(br_nzp & br_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_q      <= '{priv: 1'b1, pri: 3'd0, nzp: 3'b010};
            depth_q    <= '0;
            br_taken_q <= 1'b0;
            stk_err_q  <= 1'b0;
        end else begin
            psr_q      <= psr_d;
            depth_q    <= depth_d;
            br_taken_q <= br_taken_d;
            stk_err_q  <= stk_err_d;
        end
    end

    // Saved entries are only meaningful below depth_q, so they need no reset.
    always_ff @(posedge clk) begin
        stk_q <= stk_d;
    end

    assign psr_out   = {psr_q.priv, 4'b0, psr_q.pri, 5'b0, psr_q.nzp};
    assign n_flag    = psr_q.nzp[2];
    assign z_flag    = psr_q.nzp[1];
    assign p_flag    = psr_q.nzp[0];
    assign stk_full  = is_full;
    assign stk_empty = is_empty;
    assign stk_err   = stk_err_q;
    assign br_taken  = br_taken_q;
endmodule
